// File: rtl/serial_pkg.sv
// Shared serial-path types and defaults.
// Used by the word scheduler and the string receiver/transmitter.
package serial_pkg;

    localparam int DEF_BYTES_PER_WORD = 4;
    localparam int DEF_ACK_TIMEOUT    = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_ACK,
        WAIT_DONE,
        NEXT
    } tx_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick with last-served pointer.
// Pointer moves when the scheduler takes a pick.
module rr_arbiter2
    import serial_pkg::*;
(
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic [1:0] o_grant
);

    logic last_q;
    logic last_d;

    // Pick: a lone request wins, a tie goes to the one not served last.
    always_comb begin
        o_grant = 2'b00;
        last_d  = last_q;
        unique case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = last_q ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
        if (i_update && (o_grant != 2'b00)) begin
            last_d = o_grant[1];
        end
    end

    // Last-served pointer; reset makes requester 0 win first.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Serialises granted 32-bit words to a byte UART, MSB byte first.
// Two requesters share the UART under round-robin arbitration.
module uart_tx_scheduler
    import serial_pkg::*;
#(
    parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
    parameter int ACK_TIMEOUT    = DEF_ACK_TIMEOUT
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic [1:0]  i_req,
    input  logic [31:0] i_word0,
    input  logic [31:0] i_word1,
    input  logic        i_txd_busy,
    output logic [1:0]  o_grant,
    output logic [1:0]  o_done,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_start,
    output logic        o_active
);

    localparam int BCW = $clog2(BYTES_PER_WORD) + 1;
    localparam int TCW = $clog2(ACK_TIMEOUT) + 1;

    tx_state_e   state_q, state_d;
    logic [31:0] shift_q, shift_d;
    logic [1:0]  grant_q, grant_d;
    logic [7:0]  data_q, data_d;
    logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
    logic [TCW-1:0] to_cnt_q, to_cnt_d;
    logic [1:0]  arb_gnt;
    logic        arb_upd;

    assign arb_upd = (state_q == IDLE);

    rr_arbiter2 u_arb (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .i_req    (i_req),
        .i_update (arb_upd),
        .o_grant  (arb_gnt)
    );

    assign o_grant   = grant_q;
    assign o_tx_data = data_q;
    assign o_active  = (state_q != IDLE);

    // Next-state, datapath and pulse outputs for the word sequencer.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        grant_d    = grant_q;
        data_d     = data_q;
        byte_cnt_d = byte_cnt_q;
        to_cnt_d   = to_cnt_q;
        o_done     = 2'b00;
        o_tx_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_gnt != 2'b00) begin
                    grant_d    = arb_gnt;
                    shift_d    = arb_gnt[0] ? i_word0 : i_word1;
                    byte_cnt_d = '0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                data_d = shift_q[31:24];
                if (!i_txd_busy) begin
                    state_d = START;
                end
            end
            START: begin
                // A late busy would collide with the pulse; retry.
                if (i_txd_busy) begin
                    state_d = LOAD;
                end else begin
                    o_tx_start = 1'b1;
                    to_cnt_d   = '0;
                    state_d    = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (i_txd_busy) begin
                    state_d = WAIT_DONE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (to_cnt_d == TCW'(ACK_TIMEOUT)) begin
                        state_d = NEXT;
                    end
                end
            end
            WAIT_DONE: begin
                if (!i_txd_busy) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                shift_d    = {shift_q[23:0], 8'h00};
                byte_cnt_d = byte_cnt_q + 1'b1;
                if (byte_cnt_d < BCW'(BYTES_PER_WORD)) begin
                    state_d = LOAD;
                end else begin
                    o_done  = grant_q;
                    grant_d = 2'b00;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any word.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            grant_q    <= '0;
            data_q     <= '0;
            byte_cnt_q <= '0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            grant_q    <= grant_d;
            data_q     <= data_d;
            byte_cnt_q <= byte_cnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed and randomised bench for uart_tx_scheduler.
// Expected bytes/grants/dones come from a word-level model.
module tb_uart_tx_scheduler;

    logic        i_Clk = 1'b0;
    logic        i_Rst;
    logic [1:0]  i_req;
    logic [31:0] i_word0;
    logic [31:0] i_word1;
    logic        i_txd_busy;
    logic [1:0]  o_grant;
    logic [1:0]  o_done;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        o_active;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit uart_ack = 1'b1;

    logic [7:0] got_b[$];
    logic [7:0] exp_b[$];
    logic [1:0] got_g[$];
    logic [1:0] exp_g[$];
    logic [1:0] got_d[$];
    logic [1:0] exp_d[$];
    int         st_cyc[$];
    logic [1:0] prev_g = 2'b00;
    int         last_srv = 1;

    uart_tx_scheduler #(
        .BYTES_PER_WORD (4),
        .ACK_TIMEOUT    (16)
    ) dut (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .i_req      (i_req),
        .i_word0    (i_word0),
        .i_word1    (i_word1),
        .i_txd_busy (i_txd_busy),
        .o_grant    (o_grant),
        .o_done     (o_done),
        .o_tx_data  (o_tx_data),
        .o_tx_start (o_tx_start),
        .o_active   (o_active)
    );

    initial forever #5 i_Clk = ~i_Clk;

    initial forever begin
        @(posedge i_Clk);
        cyc++;
    end

    // UART model: busy for 10 cycles shortly after each start.
    initial begin
        i_txd_busy = 1'b0;
        forever begin
            @(negedge i_Clk);
            if (o_tx_start === 1'b1 && uart_ack) begin
                @(posedge i_Clk);
                #1 i_txd_busy = 1'b1;
                repeat (10) @(posedge i_Clk);
                #1 i_txd_busy = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge i_Clk);
        chk("grant_onehot0", 32'($onehot0(o_grant)), 1);
        chk("start_while_busy", 32'(o_tx_start & i_txd_busy), 0);
        chk("active_vs_grant", 32'(o_active), 32'(|o_grant));
        if (o_tx_start === 1'b1) begin
            got_b.push_back(o_tx_data);
            st_cyc.push_back(cyc);
        end
        if (o_done != 2'b00) got_d.push_back(o_done);
        if (o_grant != 2'b00 && o_grant != prev_g) got_g.push_back(o_grant);
        prev_g = o_grant;
    endtask

    task automatic clear_logs();
        got_b.delete(); exp_b.delete();
        got_g.delete(); exp_g.delete();
        got_d.delete(); exp_d.delete();
        st_cyc.delete();
    endtask

    function automatic int pick(input logic [1:0] req);
        if (req == 2'b11) return (last_srv == 0) ? 1 : 0;
        return (req == 2'b01) ? 0 : 1;
    endfunction

    task automatic model_word(input int r, input logic [31:0] w);
        logic [1:0] g;
        logic [31:0] sh;
        g = (r == 0) ? 2'b01 : 2'b10;
        exp_g.push_back(g);
        for (int k = 0; k < 4; k++) begin
            sh = w >> (24 - 8 * k);
            exp_b.push_back(sh[7:0]);
        end
        exp_d.push_back(g);
        last_srv = r;
    endtask

    task automatic run_done(input int n, input int budget, input string tag);
        int seen = 0;
        int t = 0;
        while (seen < n && t < budget) begin
            step();
            if (o_done != 2'b00) seen++;
            t++;
        end
        chk({tag, " done_in_budget"}, seen, n);
    endtask

    task automatic compare_logs(input string tag);
        chk({tag, " nbytes"}, got_b.size(), exp_b.size());
        for (int i = 0; i < exp_b.size() && i < got_b.size(); i++)
            chk({tag, " byte"}, got_b[i], exp_b[i]);
        chk({tag, " ngrants"}, got_g.size(), exp_g.size());
        for (int i = 0; i < exp_g.size() && i < got_g.size(); i++)
            chk({tag, " grant"}, got_g[i], exp_g[i]);
        chk({tag, " ndones"}, got_d.size(), exp_d.size());
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++)
            chk({tag, " done"}, got_d[i], exp_d[i]);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " grant"}, o_grant, 0);
        chk({tag, " done"}, o_done, 0);
        chk({tag, " start"}, o_tx_start, 0);
        chk({tag, " data"}, o_tx_data, 0);
        chk({tag, " active"}, o_active, 0);
    endtask

    task automatic do_reset();
        @(negedge i_Clk);
        i_Rst = 1'b0;
        last_srv = 1;
        repeat (3) step();
        i_Rst = 1'b1;
        clear_logs();
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] w2;
        int c0;
        int n0;
        int win;
        int dl;
        logic [1:0] r;

        i_Rst = 1'b0;
        i_req = 2'b00;
        i_word0 = '0;
        i_word1 = '0;
        #2;
        check_zero("reset");
        repeat (2) step();
        i_Rst = 1'b1;
        clear_logs();

        // Single requester, fixed word, start latency.
        step();
        c0 = cyc;
        i_req = 2'b01;
        i_word0 = 32'hDEADBEEF;
        step();
        i_req = 2'b00;
        run_done(1, 300, "single");
        repeat (3) step();
        model_word(0, 32'hDEADBEEF);
        compare_logs("single");
        if (st_cyc.size() > 0) chk("latency", st_cyc[0] - c0, 2);
        else chk("latency_nostart", 0, 1);

        // Contention straight from reset.
        do_reset();
        i_req = 2'b11;
        i_word0 = 32'h11223344;
        i_word1 = 32'hAABBCCDD;
        run_done(2, 600, "contend");
        i_req = 2'b00;
        repeat (3) step();
        win = pick(2'b11); model_word(win, win ? i_word1 : i_word0);
        win = pick(2'b11); model_word(win, win ? i_word1 : i_word0);
        compare_logs("contend");

        // Fairness over four words with random data.
        do_reset();
        i_word0 = $urandom;
        i_word1 = $urandom;
        i_req = 2'b11;
        run_done(4, 1200, "fair");
        i_req = 2'b00;
        repeat (3) step();
        for (int k = 0; k < 4; k++) begin
            win = pick(2'b11);
            model_word(win, win ? i_word1 : i_word0);
        end
        compare_logs("fair");
        n0 = 0;
        foreach (got_d[i]) if (got_d[i] == 2'b01) n0++;
        chk("fair done0_count", n0, 2);

        // UART never acknowledges.
        clear_logs();
        uart_ack = 1'b0;
        w = $urandom;
        i_word0 = w;
        i_req = 2'b01;
        step();
        i_req = 2'b00;
        run_done(1, 400, "timeout");
        uart_ack = 1'b1;
        repeat (3) step();
        model_word(0, w);
        compare_logs("timeout");
        for (int i = 1; i < st_cyc.size(); i++) begin
            dl = st_cyc[i] - st_cyc[i - 1];
            chk($sformatf("timeout spacing%0d_ok(d=%0d)", i, dl),
                32'(dl >= 17 && dl <= 20), 1);
        end

        // Word and request change after the first byte.
        clear_logs();
        w = $urandom;
        i_word0 = w;
        i_req = 2'b01;
        n0 = 0;
        while (got_b.size() < 1 && n0 < 50) begin
            step();
            n0++;
        end
        i_word0 = ~w;
        i_req = 2'b00;
        run_done(1, 300, "midword");
        repeat (3) step();
        model_word(0, w);
        compare_logs("midword");

        // Random request patterns against the model.
        clear_logs();
        for (int k = 0; k < 6; k++) begin
            r = 2'($urandom_range(1, 3));
            i_word0 = $urandom;
            i_word1 = $urandom;
            i_req = r;
            win = pick(r);
            model_word(win, win ? i_word1 : i_word0);
            run_done(1, 300, "random");
            i_req = 2'b00;
            step();
        end
        repeat (3) step();
        compare_logs("random");

        // Reset during the second byte.
        clear_logs();
        w = $urandom;
        i_word0 = w;
        i_req = 2'b01;
        step();
        i_req = 2'b00;
        n0 = 0;
        while (got_b.size() < 2 && n0 < 100) begin
            step();
            n0++;
        end
        chk("rst_mid second_byte_seen", got_b.size(), 2);
        repeat (3) step();
        #2 i_Rst = 1'b0;
        last_srv = 1;
        #1;
        check_zero("rst_mid");
        repeat (3) step();
        chk("rst_mid no_done", got_d.size(), 0);
        i_Rst = 1'b1;
        clear_logs();
        w2 = $urandom;
        i_word0 = w2;
        i_req = 2'b01;
        step();
        i_req = 2'b00;
        run_done(1, 300, "after_rst");
        repeat (3) step();
        model_word(0, w2);
        compare_logs("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
